// File: rtl/dual_mode_buffer_if.sv
// Bus bundle for dual_mode_buffer: control, data and status signals.
// master drives requests and data, slave drives data and status back.
interface dual_mode_buffer_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
);
   localparam int AW = $clog2(DEPTH);

   logic             EN;
   logic             mode;
   logic             WR;
   logic             RD;
   logic [WIDTH-1:0] dataIn;
   logic [WIDTH-1:0] dataOut;
   logic             valid_out;
   logic             EMPTY;
   logic             FULL;
   logic [AW:0]      count;
   logic             mode_act;
   logic             OVF;
   logic             UDF;

   modport master (
      output EN, mode, WR, RD, dataIn,
      input  dataOut, valid_out, EMPTY, FULL,
      input  count, mode_act, OVF, UDF
   );

   modport slave (
      input  EN, mode, WR, RD, dataIn,
      output dataOut, valid_out, EMPTY, FULL,
      output count, mode_act, OVF, UDF
   );
endinterface

// File: rtl/dual_mode_buffer.sv
// FIFO/LIFO buffer with registered read data and mode latched when empty.
// Define DUAL_MODE_BUFFER_ERR_EN to build sticky OVF/UDF error flags.
module dual_mode_buffer #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input logic              Clk,
   input logic              Rst,
   dual_mode_buffer_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];

   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      sp_q, sp_d;
   logic [AW:0]      cnt_q, cnt_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             vld_q, vld_d;
   logic             mode_q, mode_d;

   logic             empty;
   logic             full;
   logic             lifo;
   logic             rd_acc;
   logic             wr_acc;
   logic [AW:0]      sp_m1;
   logic [AW-1:0]    rd_addr;
   logic [AW-1:0]    wr_addr;

   assign empty  = (cnt_q == '0);
   assign full   = (cnt_q == DEPTH_C);
   // An empty buffer already runs in the newly requested mode on this edge.
   assign lifo   = empty ? bus.mode : mode_q;
   assign rd_acc = bus.EN & bus.RD & ~empty;
   assign wr_acc = bus.EN & bus.WR & (~full | rd_acc);
   assign sp_m1  = sp_q - 1'b1;

   // Address selection; a LIFO push+pop replaces the top entry in place.
   always_comb begin
      rd_addr = rd_ptr_q;
      wr_addr = wr_ptr_q;
      if (lifo) begin
         rd_addr = sp_m1[AW-1:0];
         wr_addr = rd_acc ? sp_m1[AW-1:0] : sp_q[AW-1:0];
      end
   end

   // Next-state for pointers, count, read data and mode.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      sp_d     = sp_q;
      cnt_d    = cnt_q;
      dout_d   = dout_q;
      vld_d    = rd_acc;
      mode_d   = mode_q;
      if (bus.EN && empty)
         mode_d = bus.mode;
      if (rd_acc)
         dout_d = mem_q[rd_addr];
      if (!lifo) begin
         if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
         if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
      end else begin
         if (wr_acc && !rd_acc) sp_d = sp_q + 1'b1;
         if (rd_acc && !wr_acc) sp_d = sp_m1;
      end
      unique case ({wr_acc, rd_acc})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   // State register with synchronous reset.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         sp_q     <= '0;
         cnt_q    <= '0;
         dout_q   <= '0;
         vld_q    <= 1'b0;
         mode_q   <= bus.mode;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         sp_q     <= sp_d;
         cnt_q    <= cnt_d;
         dout_q   <= dout_d;
         vld_q    <= vld_d;
         mode_q   <= mode_d;
      end
   end

   // Storage array, not reset; a write coinciding with reset is dropped.
   always_ff @(posedge Clk) begin
      if (wr_acc && !Rst)
         mem_q[wr_addr] <= bus.dataIn;
   end

   assign bus.dataOut   = dout_q;
   assign bus.valid_out = vld_q;
   assign bus.EMPTY     = empty;
   assign bus.FULL      = full;
   assign bus.count     = cnt_q;
   assign bus.mode_act  = mode_q;

`ifdef DUAL_MODE_BUFFER_ERR_EN
   logic ovf_q, ovf_d;
   logic udf_q, udf_d;

   // Sticky error flags: rejected write on full, read on empty.
   always_comb begin
      ovf_d = ovf_q | (bus.EN & bus.WR & full & ~rd_acc);
      udf_d = udf_q | (bus.EN & bus.RD & empty);
   end

   // Error flag register, cleared only by reset.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
         udf_q <= udf_d;
      end
   end

   assign bus.OVF = ovf_q;
   assign bus.UDF = udf_q;
`else
   assign bus.OVF = 1'b0;
   assign bus.UDF = 1'b0;
`endif
endmodule

// File: tb/tb_dual_mode_buffer.sv
// Directed bench for dual_mode_buffer: vector table plus FIFO/error sequences.
// Expected values are hand-computed; error flags follow DUAL_MODE_BUFFER_ERR_EN.
module tb_dual_mode_buffer;
   localparam int W = 8;
   localparam int D = 8;
`ifdef DUAL_MODE_BUFFER_ERR_EN
   localparam logic ERR = 1'b1;
`else
   localparam logic ERR = 1'b0;
`endif

   typedef struct {
      logic       rst;
      logic       en;
      logic       mode;
      logic       wr;
      logic       rd;
      logic [7:0] din;
      logic [7:0] dout;
      logic       vld;
      logic       empty;
      logic       full;
      logic [3:0] cnt;
      logic       mact;
   } vec_t;

   logic clk;
   logic rst;
   int   n_chk;
   int   n_fail;
   vec_t tbl[$];

   dual_mode_buffer_if #(.WIDTH(W), .DEPTH(D)) bus ();

   dual_mode_buffer #(.WIDTH(W), .DEPTH(D)) dut (
      .Clk (clk),
      .Rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int idx,
                      input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s [%0d]: got %0h expected %0h", nm, idx, act, exp);
      end
   endtask

   task automatic step(input logic r, input logic e, input logic m,
                       input logic w, input logic rd_, input logic [7:0] d);
      rst        = r;
      bus.EN     = e;
      bus.mode   = m;
      bus.WR     = w;
      bus.RD     = rd_;
      bus.dataIn = d;
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic r, input logic e, input logic m,
                      input logic w, input logic rd_, input logic [7:0] d,
                      input logic [7:0] o, input logic v, input logic em,
                      input logic fu, input logic [3:0] c, input logic ma);
      vec_t t;
      t = '{r, e, m, w, rd_, d, o, v, em, fu, c, ma};
      tbl.push_back(t);
   endtask

   initial begin
      n_chk = 0;
      n_fail = 0;
      rst = 1'b1;
      bus.EN = 1'b0;
      bus.mode = 1'b0;
      bus.WR = 1'b0;
      bus.RD = 1'b0;
      bus.dataIn = '0;

      //   rst en md wr rd din    dout  v  e  f  cnt ma
      add(1, 0, 1, 0, 0, 8'h00, 8'h00, 0, 1, 0, 0, 1);
      add(0, 1, 1, 1, 0, 8'hA0, 8'h00, 0, 0, 0, 1, 1);
      add(0, 1, 1, 1, 0, 8'hA1, 8'h00, 0, 0, 0, 2, 1);
      add(0, 1, 1, 1, 0, 8'hA2, 8'h00, 0, 0, 0, 3, 1);
      add(0, 1, 1, 0, 1, 8'h00, 8'hA2, 1, 0, 0, 2, 1);
      add(0, 1, 1, 0, 1, 8'h00, 8'hA1, 1, 0, 0, 1, 1);
      add(0, 1, 1, 0, 1, 8'h00, 8'hA0, 1, 1, 0, 0, 1);
      add(0, 1, 1, 0, 0, 8'h00, 8'hA0, 0, 1, 0, 0, 1);
      add(0, 1, 1, 0, 1, 8'h00, 8'hA0, 0, 1, 0, 0, 1);
      add(0, 1, 1, 1, 0, 8'h10, 8'hA0, 0, 0, 0, 1, 1);
      add(0, 1, 1, 1, 0, 8'h20, 8'hA0, 0, 0, 0, 2, 1);
      add(0, 1, 1, 1, 1, 8'h30, 8'h20, 1, 0, 0, 2, 1);
      add(0, 1, 1, 0, 1, 8'h00, 8'h30, 1, 0, 0, 1, 1);
      add(0, 1, 1, 0, 1, 8'h00, 8'h10, 1, 1, 0, 0, 1);
      add(0, 0, 0, 1, 0, 8'h77, 8'h10, 0, 1, 0, 0, 1);
      add(0, 0, 0, 0, 1, 8'h00, 8'h10, 0, 1, 0, 0, 1);
      add(0, 1, 0, 1, 0, 8'h01, 8'h10, 0, 0, 0, 1, 0);
      add(0, 1, 0, 1, 0, 8'h02, 8'h10, 0, 0, 0, 2, 0);
      add(0, 1, 0, 1, 0, 8'h03, 8'h10, 0, 0, 0, 3, 0);
      add(0, 1, 1, 0, 0, 8'h00, 8'h10, 0, 0, 0, 3, 0);
      add(0, 1, 1, 0, 1, 8'h00, 8'h01, 1, 0, 0, 2, 0);
      add(0, 1, 1, 0, 1, 8'h00, 8'h02, 1, 0, 0, 1, 0);
      add(0, 1, 1, 0, 1, 8'h00, 8'h03, 1, 1, 0, 0, 0);
      add(0, 1, 1, 0, 0, 8'h00, 8'h03, 0, 1, 0, 0, 1);
      add(0, 1, 1, 1, 1, 8'h44, 8'h03, 0, 0, 0, 1, 1);
      add(0, 1, 1, 0, 1, 8'h00, 8'h44, 1, 1, 0, 0, 1);
      add(0, 1, 1, 1, 0, 8'h99, 8'h44, 0, 0, 0, 1, 1);
      add(1, 1, 0, 1, 1, 8'h5A, 8'h00, 0, 1, 0, 0, 0);
      add(0, 1, 0, 0, 1, 8'h00, 8'h00, 0, 1, 0, 0, 0);

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].rst, tbl[i].en, tbl[i].mode,
              tbl[i].wr, tbl[i].rd, tbl[i].din);
         chk("dataOut", i, 32'(bus.dataOut), 32'(tbl[i].dout));
         chk("valid_out", i, 32'(bus.valid_out), 32'(tbl[i].vld));
         chk("EMPTY", i, 32'(bus.EMPTY), 32'(tbl[i].empty));
         chk("FULL", i, 32'(bus.FULL), 32'(tbl[i].full));
         chk("count", i, 32'(bus.count), 32'(tbl[i].cnt));
         chk("mode_act", i, 32'(bus.mode_act), 32'(tbl[i].mact));
      end

      // FIFO fill, overflow attempt, full read+write, drain, underflow.
      step(1, 0, 0, 0, 0, 8'h00);
      chk("rst_ovf", 0, 32'(bus.OVF), 32'(0));
      chk("rst_udf", 0, 32'(bus.UDF), 32'(0));
      for (int i = 0; i < D; i++) begin
         step(0, 1, 0, 1, 0, 8'(i + 1));
         chk("fill_cnt", i, 32'(bus.count), 32'(i + 1));
      end
      chk("fill_full", 0, 32'(bus.FULL), 32'(1));
      step(0, 1, 0, 1, 0, 8'hEE);
      chk("ovw_cnt", 0, 32'(bus.count), 32'(8));
      chk("ovw_ovf", 0, 32'(bus.OVF), 32'(ERR));
      chk("ovw_udf", 0, 32'(bus.UDF), 32'(0));
      step(0, 1, 0, 1, 1, 8'h55);
      chk("rw_dout", 0, 32'(bus.dataOut), 32'(8'h01));
      chk("rw_vld", 0, 32'(bus.valid_out), 32'(1));
      chk("rw_cnt", 0, 32'(bus.count), 32'(8));
      chk("rw_full", 0, 32'(bus.FULL), 32'(1));
      for (int i = 0; i < D; i++) begin
         step(0, 1, 0, 0, 1, 8'h00);
         chk("drain_dout", i, 32'(bus.dataOut),
             (i == D - 1) ? 32'h55 : 32'(i + 2));
         chk("drain_vld", i, 32'(bus.valid_out), 32'(1));
      end
      chk("drain_empty", 0, 32'(bus.EMPTY), 32'(1));
      step(0, 1, 0, 0, 1, 8'h00);
      chk("udf_vld", 0, 32'(bus.valid_out), 32'(0));
      chk("udf_dout", 0, 32'(bus.dataOut), 32'h55);
      chk("udf_flag", 0, 32'(bus.UDF), 32'(ERR));
      step(0, 1, 0, 1, 0, 8'h66);
      chk("stky_cnt", 0, 32'(bus.count), 32'(1));
      chk("stky_ovf", 0, 32'(bus.OVF), 32'(ERR));
      chk("stky_udf", 0, 32'(bus.UDF), 32'(ERR));
      step(1, 1, 0, 1, 0, 8'h67);
      chk("clr_cnt", 0, 32'(bus.count), 32'(0));
      chk("clr_dout", 0, 32'(bus.dataOut), 32'(0));
      chk("clr_ovf", 0, 32'(bus.OVF), 32'(0));
      chk("clr_udf", 0, 32'(bus.UDF), 32'(0));
      chk("clr_empty", 0, 32'(bus.EMPTY), 32'(1));
      step(0, 1, 0, 0, 1, 8'h00);
      chk("post_vld", 0, 32'(bus.valid_out), 32'(0));
      chk("post_cnt", 0, 32'(bus.count), 32'(0));

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule
